// File: rtl/display_pkg.sv
// Shared definitions for the BCD scan display.
// Segment bit order is seg[0]=a ... seg[6]=g, active-high.
package display_pkg;

    typedef logic [6:0] seg_t;

    localparam seg_t SEG_0    = 7'h3F;
    localparam seg_t SEG_1    = 7'h06;
    localparam seg_t SEG_2    = 7'h5B;
    localparam seg_t SEG_3    = 7'h4F;
    localparam seg_t SEG_4    = 7'h66;
    localparam seg_t SEG_5    = 7'h6D;
    localparam seg_t SEG_6    = 7'h7D;
    localparam seg_t SEG_7    = 7'h07;
    localparam seg_t SEG_8    = 7'h7F;
    localparam seg_t SEG_9    = 7'h6F;
    localparam seg_t SEG_DASH = 7'h40;
    localparam seg_t SEG_OFF  = 7'h00;

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD nibble to 7-segment decoder.
// Ports:
//   i_nibble : 4-bit BCD digit
//   o_seg    : segment pattern; nibbles 10..15 show a dash
module seg7_decode
    import display_pkg::*;
(
    input  logic [3:0] i_nibble,
    output seg_t       o_seg
);

    always_comb begin
        case (i_nibble)
            4'd0:    o_seg = SEG_0;
            4'd1:    o_seg = SEG_1;
            4'd2:    o_seg = SEG_2;
            4'd3:    o_seg = SEG_3;
            4'd4:    o_seg = SEG_4;
            4'd5:    o_seg = SEG_5;
            4'd6:    o_seg = SEG_6;
            4'd7:    o_seg = SEG_7;
            4'd8:    o_seg = SEG_8;
            4'd9:    o_seg = SEG_9;
            default: o_seg = SEG_DASH;
        endcase
    end

endmodule

// File: rtl/bcd_scan_display.sv
// Time-multiplexed 7-segment driver for a packed BCD count.
// Each digit slot lasts SCAN_DIV cycles and opens with BLANK_CYCLES of dead time.
// Ports:
//   clk      : clock, rising edge
//   rst      : asynchronous active-high reset
//   bcd      : packed BCD, bcd[3:0] is the least significant digit
//   load     : capture bcd into the display register
//   blank_lz : leading-zero suppression enable
//   seg      : segments a..g, active-high
//   an       : one-hot digit enable, all-zero during dead time
//   frame    : one-cycle pulse when the scan wraps back to digit 0
//   err      : display register holds a nibble greater than 9
module bcd_scan_display
    import display_pkg::*;
#(
    parameter int DIGITS       = 3,
    parameter int SCAN_DIV     = 1000,
    parameter int BLANK_CYCLES = 8
)(
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4*DIGITS-1:0]   bcd,
    input  logic                  load,
    input  logic                  blank_lz,
    output logic [6:0]            seg,
    output logic [DIGITS-1:0]     an,
    output logic                  frame,
    output logic                  err
);

    localparam int PW = $clog2(SCAN_DIV);
    localparam int DW = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    localparam logic [PW-1:0] P_LAST  = PW'(SCAN_DIV - 1);
    localparam logic [PW-1:0] P_BLANK = PW'(BLANK_CYCLES);
    localparam logic [DW-1:0] D_LAST  = DW'(DIGITS - 1);

    logic [4*DIGITS-1:0] r_disp;
    logic [PW-1:0]       r_p;
    logic [DW-1:0]       r_d;
    seg_t                r_seg;
    logic [DIGITS-1:0]   r_an;
    logic                r_frame;
    logic                r_err;

    logic                w_p_wrap;
    logic [PW-1:0]       w_p_nxt;
    logic [DW-1:0]       w_d_nxt;
    logic [4*DIGITS-1:0] w_disp_nxt;
    logic                w_on_nxt;
    logic [3:0]          w_nibble;
    logic [DIGITS-1:0]   w_an_nxt;
    logic [DIGITS-1:0]   w_lz_mask;
    logic                w_zero_run;
    logic                w_sup;
    logic                w_err_nxt;
    seg_t                w_dec_seg;
    seg_t                w_seg_nxt;

    // All outputs are registered from next-state values so they move on
    // the same edge as the counters and the display register.
    always_comb begin
        w_p_wrap   = (r_p == P_LAST);
        w_p_nxt    = w_p_wrap ? '0 : r_p + 1'b1;
        w_d_nxt    = r_d;
        if (w_p_wrap) begin
            w_d_nxt = (r_d == D_LAST) ? '0 : r_d + 1'b1;
        end
        w_disp_nxt = load ? bcd : r_disp;
        w_on_nxt   = (w_p_nxt >= P_BLANK);
    end

    // Walk from the most significant digit down: a digit is a leading
    // zero while every nibble from it upward is zero. Digit 0 always shows.
    always_comb begin
        w_zero_run = 1'b1;
        w_lz_mask  = '0;
        w_err_nxt  = 1'b0;
        for (int k = DIGITS - 1; k >= 0; k--) begin
            w_zero_run   = w_zero_run & (w_disp_nxt[4*k +: 4] == 4'd0);
            w_lz_mask[k] = (k != 0) && w_zero_run;
            w_err_nxt    = w_err_nxt | (w_disp_nxt[4*k +: 4] > 4'd9);
        end
    end

    always_comb begin
        w_nibble = 4'd0;
        w_an_nxt = '0;
        w_sup    = 1'b0;
        for (int k = 0; k < DIGITS; k++) begin
            if (w_d_nxt == DW'(k)) begin
                w_nibble    = w_disp_nxt[4*k +: 4];
                w_an_nxt[k] = w_on_nxt;
                w_sup       = blank_lz & w_lz_mask[k];
            end
        end
    end

    seg7_decode u_dec (
        .i_nibble (w_nibble),
        .o_seg    (w_dec_seg)
    );

    always_comb begin
        w_seg_nxt = SEG_OFF;
        if (w_on_nxt && !w_sup) begin
            w_seg_nxt = w_dec_seg;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_disp  <= '0;
            r_p     <= '0;
            r_d     <= '0;
            r_seg   <= SEG_OFF;
            r_an    <= '0;
            r_frame <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            r_disp  <= w_disp_nxt;
            r_p     <= w_p_nxt;
            r_d     <= w_d_nxt;
            r_seg   <= w_seg_nxt;
            r_an    <= w_an_nxt;
            r_frame <= w_p_wrap && (r_d == D_LAST);
            r_err   <= w_err_nxt;
        end
    end

    assign seg   = r_seg;
    assign an    = r_an;
    assign frame = r_frame;
    assign err   = r_err;

endmodule

// File: tb/tb_bcd_scan_display.sv
module tb_bcd_scan_display;

    logic        clk = 1'b0;
    logic        rst;
    logic [11:0] bcd;
    logic        load;
    logic        blank_lz;
    logic [6:0]  seg;
    logic [2:0]  an;
    logic        frame;
    logic        err;

    int n_pass  = 0;
    int n_total = 0;

    bcd_scan_display #(
        .DIGITS       (3),
        .SCAN_DIV     (16),
        .BLANK_CYCLES (2)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .bcd      (bcd),
        .load     (load),
        .blank_lz (blank_lz),
        .seg      (seg),
        .an       (an),
        .frame    (frame),
        .err      (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
    endtask

    function automatic logic [6:0] segtab(input logic [3:0] n);
        case (n)
            4'd0: return 7'h3F;
            4'd1: return 7'h06;
            4'd2: return 7'h5B;
            4'd3: return 7'h4F;
            4'd4: return 7'h66;
            4'd5: return 7'h6D;
            4'd6: return 7'h7D;
            4'd7: return 7'h07;
            4'd8: return 7'h7F;
            4'd9: return 7'h6F;
            default: return 7'h40;
        endcase
    endfunction

    // Model: outputs follow from the number of edges since reset release.
    int          m_t = 0;
    logic [11:0] m_disp = '0;
    logic [6:0]  e_seg = '0;
    logic [2:0]  e_an = '0;
    logic        e_frame = 1'b0;
    logic        e_err = 1'b0;
    int          m_p, m_d;
    logic        m_lead;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_t = 0; m_disp = '0;
            e_seg = '0; e_an = '0; e_frame = 1'b0; e_err = 1'b0;
        end else begin
            m_t = m_t + 1;
            if (load) m_disp = bcd;
            m_p = m_t % 16;
            m_d = (m_t / 16) % 3;
            e_frame = (m_t % 48 == 0);
            e_err = 1'b0;
            for (int j = 0; j < 3; j++) if (m_disp[4*j +: 4] > 4'd9) e_err = 1'b1;
            m_lead = blank_lz && (m_d != 0);
            for (int j = 0; j < 3; j++) if (j >= m_d && m_disp[4*j +: 4] != 4'd0) m_lead = 1'b0;
            if (m_p < 2) begin
                e_an = '0; e_seg = '0;
            end else begin
                e_an  = 3'(1 << m_d);
                e_seg = m_lead ? 7'h00 : segtab(m_disp[4*m_d +: 4]);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst) begin
            chk("cyc_seg",   {25'd0, seg},   {25'd0, e_seg});
            chk("cyc_an",    {29'd0, an},    {29'd0, e_an});
            chk("cyc_frame", {31'd0, frame}, {31'd0, e_frame});
            chk("cyc_err",   {31'd0, err},   {31'd0, e_err});
        end
    end

    task automatic go_to(input int target);
        int n = 0;
        while (m_t < target && n < 5000) begin
            @(negedge clk);
            n++;
        end
        chk("goto", m_t, target);
    endtask

    logic [6:0] exp_on [5];

    initial begin
        exp_on = '{7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D};
        rst = 1'b1; load = 1'b0; bcd = '0; blank_lz = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;

        // make outputs nonzero, then reset mid-slot
        go_to(2); load = 1'b1; bcd = 12'h1A3;
        go_to(3); load = 1'b0;
        go_to(20);
        chk("pre_rst_an",  an,  3'b010);
        chk("pre_rst_seg", seg, 7'h40);
        chk("pre_rst_err", err, 1'b1);
        #2 rst = 1'b1;
        #1;
        chk("rst_seg",   seg,   7'h00);
        chk("rst_an",    an,    3'b000);
        chk("rst_frame", frame, 1'b0);
        chk("rst_err",   err,   1'b0);
        @(negedge clk);
        rst = 1'b0;

        // startup
        go_to(1); chk("start_an1", an, 3'b000);
        go_to(2); chk("start_an2", an, 3'b001); chk("start_seg2", seg, 7'h3F);

        // scan order
        load = 1'b1; bcd = 12'h255;
        go_to(3); load = 1'b0;
        chk("scan_d0_seg", seg, 7'h6D);
        go_to(16); chk("scan_gap16", an, 3'b000);
        go_to(17); chk("scan_gap17", an, 3'b000);
        go_to(18); chk("scan_d1_an", an, 3'b010); chk("scan_d1_seg", seg, 7'h6D);
        go_to(34); chk("scan_d2_an", an, 3'b100); chk("scan_d2_seg", seg, 7'h5B);
        go_to(47); chk("frame47", frame, 1'b0);
        go_to(48); chk("frame48", frame, 1'b1);
        go_to(49); chk("frame49", frame, 1'b0);
        go_to(96); chk("frame96", frame, 1'b1);

        // leading-zero suppression
        blank_lz = 1'b1; load = 1'b1; bcd = 12'h007;
        go_to(97); load = 1'b0;
        go_to(98);  chk("lz007_d0", seg, 7'h07);
        go_to(114); chk("lz007_d1", seg, 7'h00); chk("lz007_d1_an", an, 3'b010);
        go_to(130); chk("lz007_d2", seg, 7'h00); chk("lz007_d2_an", an, 3'b100);
        go_to(144); load = 1'b1; bcd = 12'h000;
        go_to(145); load = 1'b0;
        go_to(146); chk("lz000_d0", seg, 7'h3F);
        go_to(162); chk("lz000_d1", seg, 7'h00);
        go_to(192); load = 1'b1; bcd = 12'h050;
        go_to(193); load = 1'b0;
        go_to(194); chk("lz050_d0", seg, 7'h3F);
        go_to(210); chk("lz050_d1", seg, 7'h6D);
        go_to(226); chk("lz050_d2", seg, 7'h00);

        // invalid nibble
        go_to(240); chk("err_before", err, 1'b0);
        blank_lz = 1'b0; load = 1'b1; bcd = 12'h1A3;
        go_to(241); load = 1'b0; chk("err_set", err, 1'b1);
        go_to(258); chk("dash_seg", seg, 7'h40); chk("dash_an", an, 3'b010);
        load = 1'b1; bcd = 12'h123;
        go_to(259); load = 1'b0;
        chk("err_clr", err, 1'b0); chk("reload_seg", seg, 7'h5B);

        // held load while digit 0 is ON
        go_to(291);
        for (int i = 0; i < 5; i++) begin
            load = 1'b1; bcd = 12'(i + 1);
            go_to(292 + i);
            chk("track_seg", seg, exp_on[i]);
            chk("track_an", an, 3'b001);
        end
        load = 1'b0;
        go_to(304); chk("track_gap304", an, 3'b000);
        go_to(305); chk("track_gap305", an, 3'b000);
        go_to(306); chk("track_d1_an", an, 3'b010); chk("track_d1_seg", seg, 7'h3F);

        // load coincident with the frame wrap
        go_to(335); load = 1'b1; bcd = 12'h999;
        go_to(336); load = 1'b0;
        chk("wrap_frame", frame, 1'b1); chk("wrap_an", an, 3'b000);
        go_to(337); chk("wrap_an337", an, 3'b000); chk("wrap_frame337", frame, 1'b0);
        go_to(338); chk("wrap_d0_an", an, 3'b001); chk("wrap_d0_seg", seg, 7'h6F);

        go_to(400);
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Time-multiplexed 7-segment driver that sits directly downstream of the counter + `bin2bcd` stage. It captures the packed BCD count on a load strobe and scans the digits one at a time. Each digit slot opens with a dead-time (anti-ghosting) interval. The block supports optional leading-zero suppression, shows invalid nibbles as a dash, and emits a per-frame pulse for the board-level display.

## Interface
- `DIGITS`, 3: number of BCD digits; legal range 1..8.
- `SCAN_DIV`, 1000: clock cycles per digit slot; must be > `BLANK_CYCLES`.
- `BLANK_CYCLES`, 8: dead-time cycles at the start of each slot; legal range ≥ 1.

Ports:
- `clk` in, 1: single clock; everything is rising-edge.
- `rst` in, 1: asynchronous, active-high reset.
- `bcd` in, 4*DIGITS: packed BCD input. `bcd[3:0]` is digit 0 (least significant).
- `load` in, 1: when high at an edge, capture `bcd` into the display register.
- `blank_lz` in, 1: leading-zero suppression enable.
- `seg` out, 7: segments, active-high, `seg[0]`=a … `seg[6]`=g.
- `an` out, DIGITS: one-hot digit enable, active-high; all-zero during dead time.
- `frame` out, 1: one-cycle pulse when the scan wraps from digit DIGITS-1 to digit 0.
- `err` out, 1: high while the display register holds any nibble > 9.

## Operation
- **State**
  - Display register `disp` (4*DIGITS bits).
  - Prescaler `p`, counting 0..SCAN_DIV-1.
  - Digit index `d`, counting 0..DIGITS-1.
- **Reset:** `disp`=0, `p`=0, `d`=0, `seg`=0, `an`=0, `frame`=0, `err`=0. All take effect immediately on `rst` assertion, regardless of clock.
- **Prescaler:** `p` increments every cycle. At `p`=SCAN_DIV-1 it wraps to 0 and `d` advances modulo DIGITS.
- **Slot phases**
  - BLANK: `p` < BLANK_CYCLES. `an`=0, `seg`=0.
  - ON: `p` ≥ BLANK_CYCLES. `an`=onehot(`d`), `seg`=decode(`disp` nibble `d`).
- **Load:** `disp` ← `bcd` on any edge with `load`=1. A held `load` recaptures every cycle. `load` has no effect on `p` or `d`.
- **Decode**
  - 0..9 map to 3F,06,5B,4F,66,6D,7D,07,7F,6F (hex).
  - Nibbles 10..15 map to 40 (dash, g only).
- **Leading-zero suppression** (`blank_lz`=1): digit k shows `seg`=0 while `an` stays driven, when nibble k and every more-significant nibble are 0.
  - Digit 0 is never suppressed.
  - An invalid nibble counts as nonzero.
- **`err`:** OR over all nibbles of `disp` of (nibble > 9).
- **Simultaneous events:** a load on the same edge as a slot or frame wrap is legal. The new `disp` is used for the digit entering ON.

## Timing
- `seg`, `an`, `frame`, `err` are registered outputs computed from next-state values. They change on the same edge as `p`/`d`/`disp`, with no extra cycle of lag.
- **After reset release:**
  - `an`=0 for the first BLANK_CYCLES-1 rising edges.
  - `an`=onehot(0) from edge BLANK_CYCLES (p = BLANK_CYCLES).
- **Load to display:** `seg` reflects new data on the capturing edge, provided the current slot is in ON.
- **`frame`:** high for exactly one cycle, on the edge where `d` goes DIGITS-1 → 0. Period is DIGITS*SCAN_DIV cycles.
- **`err`:** updates on the capturing edge.
- **Reset mid-slot:** outputs go to 0 asynchronously. The scan restarts at digit 0 in BLANK after release.

## Structure
- Package `display_pkg`:
  - Segment encoding constants SEG_0..SEG_9 and SEG_DASH.
  - SEG_OFF.
  - Typedef `seg_t` (logic [6:0]).
- Sub-module `seg7_decode`: combinational 4-bit nibble → `seg_t`, using the package constants.
- Top-level `bcd_scan_display` contains:
  - prescaler and digit counter;
  - `disp` register;
  - leading-zero mask logic;
  - a nibble mux into one `seg7_decode` instance;
  - output registers.

## Test plan
Bench uses DIGITS=3, SCAN_DIV=16, BLANK_CYCLES=2.
- **Reset and startup:** assert `rst` mid-run, then release.
  - Required: all outputs 0 immediately.
  - Required: `an`=000 at edge 1; `an`=001 and `seg`=3F from edge 2.
- **Scan order:** load `bcd`=12'h255, `blank_lz`=0.
  - Required: `an`=001 with `seg`=6D, then 010 with `seg`=6D, then 100 with `seg`=5B.
  - Required: 2 cycles of `an`=000 between slots.
  - Required: `frame` pulses every 48 cycles.
- **Leading-zero suppression:** `blank_lz`=1.
  - `bcd`=12'h007 → digits 2 and 1 give `seg`=00; digit 0 gives 07.
  - `bcd`=12'h000 → digit 0 gives 3F.
  - `bcd`=12'h050 → digit 2 gives 00; digit 1 gives 6D; digit 0 gives 3F.
- **Invalid nibble:** load 12'h1A3.
  - Required: digit 1 gives `seg`=40, and `err`=1 on the capturing edge.
  - Then reload 12'h123: `err`=0 on that edge.
- **Load during ON:** change `bcd` with `load` held while digit 0 is ON.
  - Required: `seg` tracks the new value on each capturing edge.
  - Required: `an` and `p` timing are undisturbed.
- **Coincident load and wrap:** load 12'h999 on the edge `d` wraps 2→0.
  - Required: `frame`=1 on that edge.
  - Required: digit 0 enters BLANK, then shows 6F.
